// File: rtl/pwm_ctrl_pkg.sv
// Shared encodings for the RGB fade sequencer: FSM states, switch modes and
// channel selects.
package pwm_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRampUp   = 3'd1,
      StHoldHi   = 3'd2,
      StRampDown = 3'd3,
      StHoldLo   = 3'd4,
      StStatic   = 3'd5
   } state_t;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_BREATHE = 2'd1;
   localparam logic [1:0] MODE_CYCLE   = 2'd2;
   localparam logic [1:0] MODE_STATIC  = 2'd3;

   localparam logic [1:0] CH_R   = 2'd0;
   localparam logic [1:0] CH_G   = 2'd1;
   localparam logic [1:0] CH_B   = 2'd2;
   localparam logic [1:0] CH_ALL = 2'd3;

   // Bit 0 = red, bit 1 = green, bit 2 = blue.
   function automatic logic [2:0] ch_mask(input logic [1:0] ch);
      logic [2:0] m;
      case (ch)
         CH_R:    m = 3'b001;
         CH_G:    m = 3'b010;
         CH_B:    m = 3'b100;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Fade-step prescaler: one-clock tick every STEP_DIV enabled clocks.
module pwm_tick_gen #(
   parameter int unsigned STEP_DIV = 390625
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// RGB duty sequencer: breathe / colour-cycle / static patterns chosen by the
// switches, all on the system clock with a prescaled step enable.
module pwm_fade_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned R          = 8,
   parameter int unsigned STEP_DIV   = 390625,
   parameter int unsigned STEP       = 1,
   parameter int unsigned HOLD_TICKS = 32,
   parameter int unsigned DVSR       = 4882
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sw,
   output logic [31:0] dvsr,
   output logic [R:0]  duty_r,
   output logic [R:0]  duty_g,
   output logic [R:0]  duty_b,
   output logic        cyc_done
);

   localparam logic [R+1:0] DMAX_W = (R+2)'(2 ** R);
   localparam logic [R+1:0] STEP_W = (R+2)'(STEP);
   localparam logic [R:0]   DMAX   = DMAX_W[R:0];

   state_t      state_q, state_d;
   logic [3:0]  sw_m, sw_s;
   logic [3:0]  mode_q, mode_d;
   logic [R:0]  level_q, level_d;
   logic [31:0] hold_q, hold_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        done_d;
   logic        mode_chg, tick, hold_last;
   logic [R+1:0] sum_up, diff_dn;
   logic [R:0]  lvl_up, lvl_dn;
   logic [2:0]  mask;
   logic [R:0]  duty_r_d, duty_g_d, duty_b_d;

   assign dvsr     = DVSR;
   assign mode_chg = (sw_s != mode_q);

   pwm_tick_gen #(
      .STEP_DIV (STEP_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (mode_chg),
      .en   (state_q != StIdle),
      .tick (tick)
   );

   // Widened by one bit so a large STEP cannot wrap before the clamp.
   assign sum_up    = {1'b0, level_q} + STEP_W;
   assign diff_dn   = {1'b0, level_q} - STEP_W;
   assign lvl_up    = (sum_up >= DMAX_W) ? DMAX : sum_up[R:0];
   assign lvl_dn    = ({1'b0, level_q} <= STEP_W) ? '0 : diff_dn[R:0];
   assign hold_last = ((hold_q + 32'd1) >= HOLD_TICKS);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      level_d = level_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      if (mode_chg) begin
         mode_d  = sw_s;
         state_d = StIdle;
         level_d = '0;
         hold_d  = '0;
         ptr_d   = CH_R;
      end else begin
         case (state_q)
            StIdle: begin
               case (mode_q[1:0])
                  MODE_BREATHE, MODE_CYCLE: state_d = StRampUp;
                  MODE_STATIC:              state_d = StStatic;
                  default:                  state_d = StIdle;
               endcase
            end
            StRampUp: if (tick) begin
               level_d = lvl_up;
               hold_d  = '0;
               if (lvl_up == DMAX) state_d = StHoldHi;
            end
            StHoldHi: if (tick) begin
               if (hold_last) begin
                  state_d = StRampDown;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 32'd1;
               end
            end
            StRampDown: if (tick) begin
               level_d = lvl_dn;
               if (lvl_dn == '0) state_d = StHoldLo;
            end
            StHoldLo: if (tick) begin
               if (hold_last) begin
                  state_d = StRampUp;
                  hold_d  = '0;
                  done_d  = 1'b1;
                  if (mode_q[1:0] == MODE_CYCLE) ptr_d = (ptr_q == CH_B) ? CH_R : ptr_q + 2'd1;
               end else begin
                  hold_d = hold_q + 32'd1;
               end
            end
            StStatic: level_d = DMAX;
            default:  state_d = StIdle;
         endcase
      end

      case (mode_d[1:0])
         MODE_OFF:   mask = 3'b000;
         MODE_CYCLE: mask = ch_mask(ptr_d);
         default:    mask = ch_mask(mode_d[3:2]);
      endcase
      duty_r_d = mask[0] ? level_d : '0;
      duty_g_d = mask[1] ? level_d : '0;
      duty_b_d = mask[2] ? level_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_m     <= '0;
         sw_s     <= '0;
         mode_q   <= '0;
         state_q  <= StIdle;
         level_q  <= '0;
         hold_q   <= '0;
         ptr_q    <= CH_R;
         duty_r   <= '0;
         duty_g   <= '0;
         duty_b   <= '0;
         cyc_done <= 1'b0;
      end else begin
         sw_m     <= sw;
         sw_s     <= sw_m;
         mode_q   <= mode_d;
         state_q  <= state_d;
         level_q  <= level_d;
         hold_q   <= hold_d;
         ptr_q    <= ptr_d;
         duty_r   <= duty_r_d;
         duty_g   <= duty_g_d;
         duty_b   <= duty_b_d;
         cyc_done <= done_d;
      end
   end

endmodule
